// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// imem_responder_if : fetch-side request/response bus of the instruction memory
// Revision: 1.0
// ============================================================================
interface imem_responder_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// imem_responder : instruction memory with LATENCY wait states per fetch and a
// byte-serial little-endian program-load port.
// Optional feature: define IMEM_MISALIGN_CHECK_EN to fault on req_addr[1:0] != 0.
// Revision: 1.0
// ============================================================================
module imem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  fetch,
    input  logic             load_en,
    input  logic             load_byte_valid,
    input  logic [7:0]       load_byte,
    output logic [15:0]      load_count,
    output logic             load_full
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP       = 32'h00000013;
    localparam logic [3:0]  LAST_WAIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_LOAD} state_t;
    state_t state;

    logic [31:0]   addr_q;
    logic [3:0]    wait_cnt;
    logic [1:0]    byte_lane;
    logic [23:0]   word_buf;
    logic [AW-1:0] load_ptr;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          out_of_range;
    logic          misaligned;
    logic          fault;
    logic          mem_we;
    logic [31:0]   mem_wdata;

    assign out_of_range = (addr_q[31:2] >= 30'(DEPTH_WORDS));

`ifdef IMEM_MISALIGN_CHECK_EN
    assign misaligned = |addr_q[1:0];
`else
    logic unused_addr_lsbs;
    assign misaligned       = 1'b0;
    assign unused_addr_lsbs = ^addr_q[1:0];
`endif

    assign fault     = out_of_range | misaligned;
    assign mem_we    = (state == S_LOAD) && load_en && load_byte_valid && !load_full
                       && (byte_lane == 2'd3);
    assign mem_wdata = {load_byte, word_buf};

    // Storage is deliberately outside the reset domain so a reset never loses the program.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= S_IDLE;
            fetch.req_ready <= 1'b1;
            fetch.rsp_valid <= 1'b0;
            fetch.rsp_instr <= NOP;
            fetch.rsp_err   <= 1'b0;
            load_count      <= 16'd0;
            load_full       <= 1'b0;
            wait_cnt        <= 4'd0;
            byte_lane       <= 2'd0;
            word_buf        <= 24'd0;
            load_ptr        <= '0;
            addr_q          <= 32'd0;
        end else begin
            fetch.rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        state           <= S_LOAD;
                        fetch.req_ready <= 1'b0;
                        load_ptr        <= '0;
                        byte_lane       <= 2'd0;
                        load_count      <= 16'd0;
                        load_full       <= 1'b0;
                    end else if (fetch.req_valid) begin
                        addr_q          <= fetch.req_addr;
                        wait_cnt        <= 4'd0;
                        fetch.req_ready <= 1'b0;
                        state           <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    state           <= S_IDLE;
                    fetch.req_ready <= 1'b1;
                    fetch.rsp_valid <= 1'b1;
                    fetch.rsp_err   <= fault;
                    fetch.rsp_instr <= fault ? NOP : mem[addr_q[AW+1:2]];
                end
                S_LOAD: begin
                    if (!load_en) begin
                        state           <= S_IDLE;
                        fetch.req_ready <= 1'b1;
                    end else if (load_byte_valid && !load_full) begin
                        case (byte_lane)
                            2'd0:    word_buf[7:0]   <= load_byte;
                            2'd1:    word_buf[15:8]  <= load_byte;
                            2'd2:    word_buf[23:16] <= load_byte;
                            default: ;
                        endcase
                        byte_lane <= byte_lane + 2'd1;
                        if (byte_lane == 2'd3) begin
                            load_ptr   <= load_ptr + AW'(1);
                            load_count <= load_count + 16'd1;
                            if (load_ptr == AW'(DEPTH_WORDS - 1)) begin
                                load_full <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// tb_imem_responder : vector table, directed corner sequences and randomized
// load/fetch traffic checked against a word-array reference model.
module tb_imem_responder;
    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic        load_byte_valid = 1'b0;
    logic [7:0]  load_byte = 8'd0;
    logic [15:0] load_count;
    logic        load_full;

    imem_responder_if bus();

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch           (bus),
        .load_en         (load_en),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_count      (load_count),
        .load_full       (load_full)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: program image as whole words, plus session bookkeeping.
    logic [31:0] ref_mem [DEPTH];
    int          ref_count = 0;
    bit          ref_full  = 0;
    int          ref_hi    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit ref_fault(input logic [31:0] a);
        bit f = ((a >> 2) >= DEPTH);
`ifdef IMEM_MISALIGN_CHECK_EN
        if (a % 4 != 0) f = 1;
`endif
        return f;
    endfunction

    function automatic logic [31:0] ref_instr(input logic [31:0] a);
        return ref_fault(a) ? NOP : ref_mem[a >> 2];
    endfunction

    task automatic load_session(input string name, input byte_q_t bytes, input bit gaps);
        logic [31:0] stage = 32'd0;
        int          n = 0;
        load_en = 1'b1;
        @(posedge clk); #1;
        ref_count = 0;
        ref_full  = 0;
        foreach (bytes[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                load_byte_valid = 1'b0;
                @(posedge clk); #1;
            end
            load_byte_valid = 1'b1;
            load_byte       = bytes[i];
            @(posedge clk); #1;
            if (!ref_full) begin
                stage[8*(n%4) +: 8] = bytes[i];
                n++;
                if (n % 4 == 0) begin
                    ref_mem[n/4 - 1] = stage;
                    ref_count++;
                    if (ref_count > ref_hi) ref_hi = ref_count;
                    if (ref_count == DEPTH) ref_full = 1;
                end
            end
        end
        load_byte_valid = 1'b0;
        chk($sformatf("%s_count", name), 32'(load_count), 32'(ref_count));
        chk($sformatf("%s_full", name), 32'(load_full), 32'(ref_full));
        load_en = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s_ready_after", name), 32'(bus.req_ready), 32'd1);
    endtask

    task automatic fetch(input string name, input logic [31:0] a,
                         input logic [31:0] exp_instr, input logic exp_err);
        int edges = 0;
        chk($sformatf("%s_ready", name), 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        chk($sformatf("%s_busy", name), 32'(bus.req_ready), 32'd0);
        while (edges < 20 && !bus.rsp_valid) begin
            @(posedge clk); #1;
            edges++;
        end
        chk($sformatf("%s_latency", name), 32'(edges), 32'(LAT + 1));
        chk($sformatf("%s_instr", name), bus.rsp_instr, exp_instr);
        chk($sformatf("%s_err", name), 32'(bus.rsp_err), 32'(exp_err));
        chk($sformatf("%s_ready_back", name), 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        chk($sformatf("%s_pulse", name), 32'(bus.rsp_valid), 32'd0);
        chk($sformatf("%s_hold", name), bus.rsp_instr, exp_instr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[7];
        byte_q_t     q;
        logic [31:0] a;
        int          edges;
        bit          seen;

        // Expected results after loading 13 05 A0 00 93 05 B0 00.
        vecs[0] = '{32'h0000_0004, 32'h00B0_0593, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h00A0_0513, 1'b0};
        vecs[2] = '{32'h0000_0400, NOP,           1'b1};
        vecs[3] = '{32'hFFFF_FFFC, NOP,           1'b1};
        vecs[4] = '{32'h0000_0401, NOP,           1'b1};
`ifdef IMEM_MISALIGN_CHECK_EN
        vecs[5] = '{32'h0000_0006, NOP,           1'b1};
        vecs[6] = '{32'h0000_0001, NOP,           1'b1};
`else
        vecs[5] = '{32'h0000_0006, 32'h00B0_0593, 1'b0};
        vecs[6] = '{32'h0000_0001, 32'h00A0_0513, 1'b0};
`endif

        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_instr", bus.rsp_instr, NOP);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_load_full", 32'(load_full), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 32'(bus.req_ready), 32'd1);

        q = {8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        load_session("load8", q, 0);
        for (int i = 0; i < 7; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].err);
        end

        // Randomized sessions (lengths need not be whole words) and fetches.
        for (int s = 0; s < 2; s++) begin
            q.delete();
            repeat ($urandom_range(9, 150)) q.push_back(8'($urandom));
            load_session($sformatf("rload%0d", s), q, 1);
            for (int k = 0; k < 15; k++) begin
                case ($urandom_range(0, 7))
                    6:       a = 32'($urandom_range(0, ref_hi - 1)) * 4 + 32'($urandom_range(1, 3));
                    7:       a = 32'(DEPTH * 4) + ($urandom % 32'hFFFF_F000);
                    default: a = 32'($urandom_range(0, ref_hi - 1)) * 4;
                endcase
                fetch($sformatf("rfetch%0d_%0d", s, k), a, ref_instr(a), ref_fault(a));
            end
        end

        // Overfill: 1027 bytes, the last three must be dropped.
        q.delete();
        repeat (DEPTH * 4 + 3) q.push_back(8'($urandom));
        load_session("full", q, 0);
        fetch("full_first", 32'h0, ref_mem[0], 1'b0);
        fetch("full_last", 32'(DEPTH * 4 - 4), ref_mem[DEPTH-1], 1'b0);

        // load_en wins over req_valid in IDLE.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        load_en       = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("prio_ready", 32'(bus.req_ready), 32'd0);
        chk("prio_count_clr", 32'(load_count), 32'd0);
        chk("prio_full_clr", 32'(load_full), 32'd0);
        seen = 0;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1;
        end
        chk("prio_no_rsp", 32'(seen), 32'd0);
        load_en = 1'b0;
        @(posedge clk); #1;
        chk("prio_ready_back", 32'(bus.req_ready), 32'd1);
        ref_count = 0;
        ref_full  = 0;

        // load_en raised during WAIT leaves the fetch intact, LOAD follows.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        load_en       = 1'b1;
        edges = 0;
        while (edges < 20 && !bus.rsp_valid) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("wload_latency", 32'(edges), 32'(LAT + 1));
        chk("wload_instr", bus.rsp_instr, ref_mem[2]);
        @(posedge clk); #1;
        chk("wload_in_load", 32'(bus.req_ready), 32'd0);
        load_en = 1'b0;
        @(posedge clk); #1;
        chk("wload_ready_back", 32'(bus.req_ready), 32'd1);

        // Reset during WAIT aborts the fetch silently; memory survives.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'hC;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("wrst_ready_async", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        repeat (LAT + 4) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1;
        end
        chk("wrst_no_rsp", 32'(seen), 32'd0);
        chk("wrst_instr", bus.rsp_instr, NOP);
        chk("wrst_load_count", 32'(load_count), 32'd0);
        fetch("wrst_retained", 32'hC, ref_mem[3], 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
